// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage core: merges load-use, MDU occupancy,
// MEM IO wait, taken-branch flush and external halt into one prefix-closed freeze vector.
module hazard_stall_ctrl #(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       chip_enable,
  input  logic       load_use_req,
  input  logic       mdu_start,
  input  logic       mem_wait,
  input  logic       branch_flag,
  input  logic       halt_req,
  output logic [5:0] stall,
  output logic       flush_if,
  output logic       bubble_ex,
  output logic       mdu_busy,
  output logic       mdu_done,
  output logic       halted
);

  localparam logic [5:0] MASK_NONE = 6'b000000;
  localparam logic [5:0] MASK_LU   = 6'b000011;
  localparam logic [5:0] MASK_MDU  = 6'b000111;
  localparam logic [5:0] MASK_MW   = 6'b001111;
  localparam logic [5:0] MASK_ALL  = 6'b111111;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_MDU,
    S_HALT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [5:0]       stall_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Masks are nested prefixes, so OR-ing contributions yields the largest one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = MASK_NONE;
    mdu_busy  = 1'b0;
    mdu_done  = 1'b0;
    halted    = 1'b0;

    case (state)
      S_IDLE: begin
        stall_c = MASK_ALL;
        if (chip_enable) state_nxt = S_RUN;
      end

      S_RUN: begin
        if (load_use_req) stall_c = stall_c | MASK_LU;
        if (mem_wait)     stall_c = stall_c | MASK_MW;
        if (halt_req)     stall_c = stall_c | MASK_ALL;
        if (mdu_start && !halt_req && !mem_wait) begin
          stall_c   = stall_c | MASK_MDU;
          cnt_nxt   = CNT_INIT;
          state_nxt = S_MDU;
        end else if (halt_req) begin
          state_nxt = S_HALT;
        end
      end

      S_MDU: begin
        mdu_busy = 1'b1;
        // halt_req is deferred here; it only steers the exit once the op finishes.
        if (cnt != '0) begin
          stall_c = stall_c | MASK_MDU;
          cnt_nxt = cnt - 1'b1;
        end else begin
          mdu_done  = 1'b1;
          state_nxt = halt_req ? S_HALT : S_RUN;
        end
        if (load_use_req) stall_c = stall_c | MASK_LU;
        if (mem_wait)     stall_c = stall_c | MASK_MW;
      end

      S_HALT: begin
        stall_c = MASK_ALL;
        halted  = 1'b1;
        if (!halt_req) state_nxt = S_RUN;
      end

      default: begin
        stall_c   = MASK_ALL;
        state_nxt = S_IDLE;
      end
    endcase

    if (!chip_enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end
  end

  assign stall     = stall_c;
  assign flush_if  = branch_flag & ~stall_c[1];
  assign bubble_ex = stall_c[1] & ~stall_c[2];

endmodule
